// File: rtl/hub75_pkg.sv
// Shared constants, types and helpers for the HUB75 receive path.
package hub75_pkg;

  localparam int DEF_COLOR_COUNT   = 3;
  localparam int DEF_COL_ADDR_BITS = 6;
  localparam int ROW_ELEM          = 1 << DEF_COL_ADDR_BITS;
  localparam int COLOR_DAT_WIDTH   = ROW_ELEM;
  localparam int ROW_DAT_WIDTH     = DEF_COLOR_COUNT * COLOR_DAT_WIDTH;

  typedef enum logic {
    ON_DARK = 1'b0,
    ON_LIT  = 1'b1
  } on_state_e;

  // Extract colour lane c from a flattened row; lane c sits at [c*ROW_ELEM +: ROW_ELEM].
  function automatic logic [COLOR_DAT_WIDTH-1:0] lane_slice(
    input logic [ROW_DAT_WIDTH-1:0] d,
    input int unsigned              c
  );
    return d[c*COLOR_DAT_WIDTH +: COLOR_DAT_WIDTH];
  endfunction

endpackage

// File: rtl/hub75_sync_edge.sv
// Multi-stage input synchronizer with reset-to-idle level and optional edge pulses.
module hub75_sync_edge
  import hub75_pkg::*;
#(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter bit             EDGE    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;

  // Shift the raw input one stage further down the chain every cycle.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Synchronizer chain; resets to the idle level so release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

  if (EDGE) begin : g_edge
    logic [W-1:0] prev_q, prev_d;

    // Previous synced level, used as the edge reference.
    always_comb prev_d = q;

    // One extra registered copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= RST_VAL;
      else        prev_q <= prev_d;
    end

    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
  end else begin : g_no_edge
    assign rise = '0;
    assign fall = '0;
  end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: rebuilds latched bit-plane rows and measures output-enable on-time.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLOR_COUNT   = 3,
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ON_CNT_BITS   = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     hub_clk,
  input  logic                                     hub_lat,
  input  logic                                     hub_noe,
  input  logic [ROW_ADDR_BITS-1:0]                 hub_mux,
  input  logic [COLOR_COUNT-1:0]                   s_in,
  output logic [COLOR_COUNT*(1<<COL_ADDR_BITS)-1:0] plane_data,
  output logic [ROW_ADDR_BITS-1:0]                 plane_row,
  output logic                                     plane_valid,
  output logic                                     plane_err,
  output logic [ON_CNT_BITS-1:0]                   on_cycles,
  output logic [ROW_ADDR_BITS-1:0]                 on_row,
  output logic                                     on_valid
);

  localparam int ROW_W = 1 << COL_ADDR_BITS;
  localparam int CNT_W = COL_ADDR_BITS + 1;
  localparam int BUS_W = ROW_ADDR_BITS + COLOR_COUNT;
  localparam logic [CNT_W-1:0] CNT_ROW = CNT_W'(ROW_W);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ROW_W + 1);

  // ---------------- synchronizers ----------------
  logic clk_rise, lat_rise, noe_rise, noe_fall;
  logic hclk_lvl_unused, hclk_fall_unused, lat_lvl_unused, lat_fall_unused, noe_lvl_unused;
  logic [BUS_W-1:0] bus_s, bus_rise_unused, bus_fall_unused;
  logic [ROW_ADDR_BITS-1:0] mux_s;
  logic [COLOR_COUNT-1:0]   sin_s;

  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .d(hub_clk),
    .q(hclk_lvl_unused), .rise(clk_rise), .fall(hclk_fall_unused)
  );

  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_lat (
    .clk(clk), .rst_n(rst_n), .d(hub_lat),
    .q(lat_lvl_unused), .rise(lat_rise), .fall(lat_fall_unused)
  );

  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE(1'b1)) u_sync_noe (
    .clk(clk), .rst_n(rst_n), .d(hub_noe),
    .q(noe_lvl_unused), .rise(noe_rise), .fall(noe_fall)
  );

  // Row address and colour data share one bus so they stay aligned with the strobes.
  hub75_sync_edge #(.W(BUS_W), .STAGES(SYNC_STAGES), .RST_VAL('0), .EDGE(1'b0)) u_sync_bus (
    .clk(clk), .rst_n(rst_n), .d({hub_mux, s_in}),
    .q(bus_s), .rise(bus_rise_unused), .fall(bus_fall_unused)
  );

  assign {mux_s, sin_s} = bus_s;

  // ---------------- shift / latch path ----------------
  logic [COLOR_COUNT-1:0][ROW_W-1:0] sr_q, sr_d;
  logic [COLOR_COUNT-1:0][ROW_W-1:0] plane_data_q, plane_data_d;
  logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [ROW_ADDR_BITS-1:0]          plane_row_q, plane_row_d;
  logic                              plane_valid_q, plane_valid_d;
  logic                              plane_err_q, plane_err_d;

  // Shift first, then latch, so a coincident hub_clk/hub_lat edge includes the new bit.
  always_comb begin
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    plane_data_d  = plane_data_q;
    plane_row_d   = plane_row_q;
    plane_err_d   = plane_err_q;
    plane_valid_d = 1'b0;
    if (clk_rise) begin
      for (int c = 0; c < COLOR_COUNT; c++) sr_d[c] = {sr_q[c][ROW_W-2:0], sin_s[c]};
      if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (lat_rise) begin
      plane_data_d  = sr_d;
      plane_row_d   = mux_s;
      plane_err_d   = (bit_cnt_d != CNT_ROW);
      plane_valid_d = 1'b1;
      bit_cnt_d     = '0;
    end
  end

  // Shift register, bit counter and latched plane outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      plane_data_q  <= '0;
      plane_row_q   <= '0;
      plane_err_q   <= 1'b0;
      plane_valid_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      plane_data_q  <= plane_data_d;
      plane_row_q   <= plane_row_d;
      plane_err_q   <= plane_err_d;
      plane_valid_q <= plane_valid_d;
    end
  end

  assign plane_data  = plane_data_q;
  assign plane_row   = plane_row_q;
  assign plane_err   = plane_err_q;
  assign plane_valid = plane_valid_q;

  // ---------------- on-time FSM ----------------
  on_state_e                state_q, state_d;
  logic [ON_CNT_BITS-1:0]   on_cnt_q, on_cnt_d;
  logic [ROW_ADDR_BITS-1:0] pend_row_q, pend_row_d;
  logic [ON_CNT_BITS-1:0]   on_cycles_q, on_cycles_d;
  logic [ROW_ADDR_BITS-1:0] on_row_q, on_row_d;
  logic                     on_valid_q, on_valid_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ON_DARK;
    else        state_q <= state_d;
  end

  // Next state: lit between a synced noe fall and the following rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ON_DARK: if (noe_fall) state_d = ON_LIT;
      ON_LIT:  if (noe_rise) state_d = ON_DARK;
      default: state_d = ON_DARK;
    endcase
  end

  // Datapath: count lit cycles, report count and row when the period ends.
  always_comb begin
    on_cnt_d    = on_cnt_q;
    pend_row_d  = pend_row_q;
    on_cycles_d = on_cycles_q;
    on_row_d    = on_row_q;
    on_valid_d  = 1'b0;
    case (state_q)
      ON_DARK: begin
        if (noe_fall) begin
          on_cnt_d   = ON_CNT_BITS'(1);
          pend_row_d = mux_s;
        end
      end
      ON_LIT: begin
        if (noe_rise) begin
          on_cycles_d = on_cnt_q;
          on_row_d    = pend_row_q;
          on_valid_d  = 1'b1;
        end else if (on_cnt_q != '1) begin
          on_cnt_d = on_cnt_q + ON_CNT_BITS'(1);
        end
      end
      default: ;
    endcase
  end

  // On-time counter and reported outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_cnt_q    <= '0;
      pend_row_q  <= '0;
      on_cycles_q <= '0;
      on_row_q    <= '0;
      on_valid_q  <= 1'b0;
    end else begin
      on_cnt_q    <= on_cnt_d;
      pend_row_q  <= pend_row_d;
      on_cycles_q <= on_cycles_d;
      on_row_q    <= on_row_d;
      on_valid_q  <= on_valid_d;
    end
  end

  assign on_cycles = on_cycles_q;
  assign on_row    = on_row_q;
  assign on_valid  = on_valid_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: reset, row rebuild, shift-count errors, on-time.
module tb_hub75_rx;
  import hub75_pkg::*;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hub_clk = 1'b0;
  logic         hub_lat = 1'b0;
  logic         hub_noe = 1'b1;
  logic [3:0]   hub_mux = '0;
  logic [2:0]   s_in = '0;

  logic [191:0] plane_data;
  logic [3:0]   plane_row;
  logic         plane_valid, plane_err;
  logic [15:0]  on_cycles;
  logic [3:0]   on_row;
  logic         on_valid;

  logic [191:0] u8_plane_data_unused;
  logic [3:0]   u8_plane_row_unused, u8_on_row_unused;
  logic         u8_plane_valid_unused, u8_plane_err_unused, u8_on_valid_unused;
  logic [7:0]   u8_on_cycles;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int ov_cnt = 0;

  hub75_rx #(.COLOR_COUNT(3), .COL_ADDR_BITS(6), .ROW_ADDR_BITS(4),
             .SYNC_STAGES(S), .ON_CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_noe(hub_noe),
    .hub_mux(hub_mux), .s_in(s_in), .plane_data(plane_data), .plane_row(plane_row),
    .plane_valid(plane_valid), .plane_err(plane_err), .on_cycles(on_cycles),
    .on_row(on_row), .on_valid(on_valid)
  );

  hub75_rx #(.COLOR_COUNT(3), .COL_ADDR_BITS(6), .ROW_ADDR_BITS(4),
             .SYNC_STAGES(S), .ON_CNT_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_noe(hub_noe),
    .hub_mux(hub_mux), .s_in(s_in), .plane_data(u8_plane_data_unused),
    .plane_row(u8_plane_row_unused), .plane_valid(u8_plane_valid_unused),
    .plane_err(u8_plane_err_unused), .on_cycles(u8_on_cycles),
    .on_row(u8_on_row_unused), .on_valid(u8_on_valid_unused)
  );

  always #5 clk = ~clk;

  // Pulses last one full cycle, so each is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (plane_valid) pv_cnt++;
    if (on_valid)    ov_cnt++;
  end

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  // One hub_clk pulse: high one cycle, low one cycle; optional lat rise with it.
  task automatic pulse(input logic [2:0] bits, input bit lat);
    @(negedge clk);
    hub_clk = 1'b1;
    s_in    = bits;
    if (lat) hub_lat = 1'b1;
    @(negedge clk);
    hub_clk = 1'b0;
  endtask

  // Bit i of lN is sent on pulse i; pulses beyond 64 send zeros.
  task automatic send_row(input int n, input logic [63:0] l0, input logic [63:0] l1,
                          input logic [63:0] l2, input bit lat_on_last);
    logic [2:0] b;
    for (int i = 0; i < n; i++) begin
      if (i < 64) b = {l2[i], l1[i], l0[i]};
      else        b = 3'b000;
      pulse(b, lat_on_last && (i == n - 1));
    end
  endtask

  // Raise lat (unless already high), wait a bounded time for plane_valid, drop lat.
  task automatic latch_wait(input string name);
    bit got = 1'b0;
    if (!hub_lat) begin
      @(negedge clk);
      hub_lat = 1'b1;
    end
    for (int k = 0; k < 16 && !got; k++) begin
      @(posedge clk); #1;
      if (plane_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_valid_timeout: plane_valid=0 expected 1", name);
    end
    @(negedge clk);
    hub_lat = 1'b0;
  endtask

  task automatic wait_on(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(posedge clk); #1;
      if (on_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_on_timeout: on_valid=0 expected 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hub_clk = i[0]; hub_lat = i[1]; hub_noe = i[2]; hub_mux = 4'(i); s_in = 3'(i);
    end
    @(negedge clk);
    hub_clk = 0; hub_lat = 0; hub_noe = 1; hub_mux = 0; s_in = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pv_cnt = 0; ov_cnt = 0;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (pv_cnt !== 0) begin errors++; $display("FAIL reset_pv_cnt: got %0d expected 0", pv_cnt); end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL reset_ov_cnt: got %0d expected 0", ov_cnt); end
    checks++; if (plane_data !== '0) begin errors++; $display("FAIL reset_plane_data: got %h expected 0", plane_data); end
    checks++; if ({plane_row, plane_err, plane_valid} !== 6'd0) begin errors++; $display("FAIL reset_plane_ctl: got %b expected 0", {plane_row, plane_err, plane_valid}); end
    checks++; if ({on_cycles, on_row, on_valid} !== 21'd0) begin errors++; $display("FAIL reset_on: got %h expected 0", {on_cycles, on_row, on_valid}); end
  endtask

  task automatic test_full_row();
    hub_mux = 4'd5;
    pv_cnt  = 0;
    send_row(64, 64'h1, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    hub_lat = 1'b1;
    repeat (S) @(posedge clk);
    #1;
    checks++; if (plane_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", plane_valid); end
    @(posedge clk); #1;
    checks++; if (plane_valid !== 1'b1) begin errors++; $display("FAIL full_latency_valid: got %b expected 1", plane_valid); end
    checks++; if (plane_data !== {64'h0, 64'h0, 64'h8000_0000_0000_0000}) begin errors++; $display("FAIL full_data: got %h expected %h", plane_data, {64'h0, 64'h0, 64'h8000_0000_0000_0000}); end
    checks++; if (plane_row !== 4'd5) begin errors++; $display("FAIL full_row: got %0d expected 5", plane_row); end
    checks++; if (plane_err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", plane_err); end
    @(posedge clk); #1;
    checks++; if (plane_valid !== 1'b0) begin errors++; $display("FAIL full_pulse_width: got %b expected 0", plane_valid); end
    @(negedge clk);
    hub_lat = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (pv_cnt !== 1) begin errors++; $display("FAIL full_pulse_count: got %0d expected 1", pv_cnt); end
  endtask

  task automatic test_short_long();
    send_row(63, 64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF, 1'b0);
    latch_wait("short");
    checks++; if (plane_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", plane_err); end
    send_row(65, 64'h5555, 64'h0, 64'h0, 1'b0);
    latch_wait("long");
    checks++; if (plane_err !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", plane_err); end
    send_row(64, 64'hDEAD_BEEF_0000_0001, 64'hF0F0_0000_FFFF_1234, 64'h8000_0000_0000_0003, 1'b0);
    latch_wait("exact");
    checks++; if (plane_err !== 1'b0) begin errors++; $display("FAIL exact_err: got %b expected 0", plane_err); end
    checks++; if (plane_data !== {64'hC000_0000_0000_0001, 64'h2C48_FFFF_0000_0F0F, 64'h8000_0000_F77D_B57B})
      begin errors++; $display("FAIL exact_data: got %h expected %h", plane_data, {64'hC000_0000_0000_0001, 64'h2C48_FFFF_0000_0F0F, 64'h8000_0000_F77D_B57B}); end
  endtask

  task automatic test_simultaneous();
    send_row(64, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 1'b1);
    latch_wait("simul");
    checks++; if (plane_err !== 1'b0) begin errors++; $display("FAIL simul_err: got %b expected 0", plane_err); end
    checks++; if (lane_slice(plane_data, 0) !== 64'h1) begin errors++; $display("FAIL simul_col0: got %h expected 1", lane_slice(plane_data, 0)); end
  endtask

  task automatic test_on_time();
    hub_mux = 4'd9;
    ov_cnt  = 0;
    @(negedge clk);
    hub_noe = 1'b0;
    repeat (10) @(negedge clk);
    hub_mux = 4'd3;
    repeat (27) @(negedge clk);
    hub_noe = 1'b1;
    wait_on("on37");
    checks++; if (on_cycles !== 16'd37) begin errors++; $display("FAIL on37_cycles: got %0d expected 37", on_cycles); end
    checks++; if (on_row !== 4'd9) begin errors++; $display("FAIL on37_row: got %0d expected 9", on_row); end
    checks++; if (u8_on_cycles !== 8'd37) begin errors++; $display("FAIL on37_cycles8: got %0d expected 37", u8_on_cycles); end
    repeat (5) @(negedge clk);
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL on37_pulse_count: got %0d expected 1", ov_cnt); end
    hub_mux = 4'd12;
    @(negedge clk);
    hub_noe = 1'b0;
    repeat (300) @(negedge clk);
    hub_noe = 1'b1;
    wait_on("on300");
    checks++; if (on_cycles !== 16'd300) begin errors++; $display("FAIL on300_cycles: got %0d expected 300", on_cycles); end
    checks++; if (u8_on_cycles !== 8'd255) begin errors++; $display("FAIL on300_sat8: got %0d expected 255", u8_on_cycles); end
    checks++; if (on_row !== 4'd12) begin errors++; $display("FAIL on300_row: got %0d expected 12", on_row); end
  endtask

  task automatic test_patterns();
    logic [63:0] l0, l1, l2;
    for (int r = 0; r < 16; r++) begin
      hub_mux = 4'(r);
      l0 = {16{4'(r)}};
      l1 = ~l0;
      l2 = 64'hA00A_00A0_0A00_A00A;
      send_row(64, l0, l1, l2, 1'b0);
      latch_wait("pattern");
      checks++;
      if (plane_data !== {rev64(l2), rev64(l1), rev64(l0)} || plane_row !== 4'(r) || plane_err !== 1'b0) begin
        errors++;
        $display("FAIL pattern_row%0d: got %h/%0d/%b expected %h/%0d/0", r, plane_data, plane_row, plane_err,
                 {rev64(l2), rev64(l1), rev64(l0)}, r);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    send_row(30, 64'hFFFF_FFFF, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    pv_cnt = 0;
    repeat (10) @(negedge clk);
    checks++; if (pv_cnt !== 0 || plane_data !== '0) begin errors++; $display("FAIL midreset_state: got pulses %0d data %h expected 0", pv_cnt, plane_data); end
    hub_mux = 4'd7;
    send_row(64, 64'h0F, 64'h0, 64'hF000_0000_0000_0000, 1'b0);
    latch_wait("midreset");
    checks++; if (plane_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", plane_err); end
    checks++; if (plane_data !== {64'h0000_0000_0000_000F, 64'h0, 64'hF000_0000_0000_0000})
      begin errors++; $display("FAIL midreset_data: got %h expected %h", plane_data, {64'h0000_0000_0000_000F, 64'h0, 64'hF000_0000_0000_0000}); end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_short_long();
    test_simultaneous();
    test_on_time();
    test_patterns();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
